// File: rtl/chirp_sequencer.sv
// ---------------------------------------------------------------------------
// chirp_sequencer
//   Linear FM sweep sequencer feeding the NCO phase accumulator. Issues the
//   phase-increment word start + k*step, each word held dwell+1 cycles, in
//   single-shot, sawtooth-repeat or triangle-repeat form.
//
//   Ports
//     clk, rst_n            system clock, async active-low reset
//     cfg_valid/cfg_ready   config write handshake (ready only in IDLE)
//     cfg_start, cfg_step   first word and per-step delta (mod 2**DSIZE)
//     cfg_nsteps            index of the last word in a sweep
//     cfg_dwell             each word is held dwell+1 cycles
//     cfg_mode              0 single, 1 sawtooth, 2 triangle, 3 as 0
//     go, abort             start sweep (IDLE only) / return to IDLE
//     busy                  sweep in progress
//     incr_out, incr_valid  current increment word, pulse on each new word
//     sweep_start           pulse when index 0 is issued going up
//     sweep_done            pulse when a single-shot sweep completes
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for go; config writes accepted; incr_out held
//   SWEEP_UP   | issuing words with idx rising (incr_out += step)
//   SWEEP_DOWN | triangle return leg, idx falling (incr_out -= step)
// ---------------------------------------------------------------------------
module chirp_sequencer #(
    parameter int DSIZE   = 20,
    parameter int NSTEP_W = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DSIZE-1:0]   cfg_start,
    input  logic [DSIZE-1:0]   cfg_step,
    input  logic [NSTEP_W-1:0] cfg_nsteps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               go,
    input  logic               abort,
    output logic               busy,
    output logic [DSIZE-1:0]   incr_out,
    output logic               incr_valid,
    output logic               sweep_start,
    output logic               sweep_done
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DSIZE-1:0]   start_q, start_d;
    logic [DSIZE-1:0]   step_q, step_d;
    logic [NSTEP_W-1:0] nsteps_q, nsteps_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         mode_q, mode_d;
    logic [DSIZE-1:0]   incr_q, incr_d;
    logic [NSTEP_W-1:0] idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               start_pls_q, start_pls_d;
    logic               done_q, done_d;

    logic               cfg_wr;
    logic               repeat_mode;
    logic [DSIZE-1:0]   start_eff;
    logic [DWELL_W-1:0] dwell_eff;

    assign cfg_wr      = cfg_valid && (state_q == IDLE);
    assign repeat_mode = (mode_q == 2'd1) || (mode_q == 2'd2);
    // A write landing with go must already be in effect for that sweep.
    assign start_eff   = cfg_wr ? cfg_start : start_q;
    assign dwell_eff   = cfg_wr ? cfg_dwell : dwell_q;

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        step_d      = step_q;
        nsteps_d    = nsteps_q;
        dwell_d     = dwell_q;
        mode_d      = mode_q;
        incr_d      = incr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        start_pls_d = 1'b0;
        done_d      = 1'b0;

        if (cfg_wr) begin
            start_d  = cfg_start;
            step_d   = cfg_step;
            nsteps_d = cfg_nsteps;
            dwell_d  = cfg_dwell;
            mode_d   = cfg_mode;
        end

        case (state_q)
            IDLE: begin
                if (go && !abort) begin
                    state_d     = SWEEP_UP;
                    incr_d      = start_eff;
                    idx_d       = '0;
                    cnt_d       = dwell_eff;
                    valid_d     = 1'b1;
                    start_pls_d = 1'b1;
                end
            end

            SWEEP_UP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d   = dwell_q;
                    valid_d = 1'b1;
                    if (idx_q != nsteps_q) begin
                        idx_d  = idx_q + NSTEP_W'(1);
                        incr_d = incr_q + step_q;
                    end else if ((mode_q == 2'd2) && (nsteps_q != '0)) begin
                        // Peak is not repeated: the down leg starts at nsteps-1.
                        state_d     = SWEEP_DOWN;
                        idx_d       = idx_q - NSTEP_W'(1);
                        incr_d      = incr_q - step_q;
                        start_pls_d = (nsteps_q == NSTEP_W'(1));
                    end else if (repeat_mode) begin
                        // Reload rather than wrap arithmetically back to start.
                        idx_d       = '0;
                        incr_d      = start_q;
                        start_pls_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            SWEEP_DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d   = dwell_q;
                    valid_d = 1'b1;
                    if (idx_q == '0) begin
                        // Base is not repeated: the up leg resumes at idx 1.
                        state_d = SWEEP_UP;
                        idx_d   = NSTEP_W'(1);
                        incr_d  = incr_q + step_q;
                    end else begin
                        idx_d       = idx_q - NSTEP_W'(1);
                        incr_d      = incr_q - step_q;
                        start_pls_d = (idx_q == NSTEP_W'(1));
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= '0;
            step_q      <= '0;
            nsteps_q    <= '0;
            dwell_q     <= '0;
            mode_q      <= '0;
            incr_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            start_pls_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            step_q      <= step_d;
            nsteps_q    <= nsteps_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode_d;
            incr_q      <= incr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            start_pls_q <= start_pls_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign incr_out    = incr_q;
    assign incr_valid  = valid_q;
    assign sweep_start = start_pls_q;
    assign sweep_done  = done_q;

endmodule
